// File: rtl/mips_pkg.sv
// Shared pipeline types for the MIPS-style hazard unit:
// forwarding codes, scoreboard entry layout and defaults.
package mips_pkg;

  localparam int NREGS_DEF   = 32;
  localparam int MAX_AGE_DEF = 2;

  typedef enum logic [1:0] {
    FWD_REGFILE = 2'b00,
    FWD_MEM_WB  = 2'b01,
    FWD_EX_MEM  = 2'b10
  } fwd_e;

  typedef struct packed {
    logic       valid;
    logic       is_load;
    logic [1:0] age;
  } sb_entry_t;

  // A load still in EX has no result yet, so it never forwards from EX/MEM.
  function automatic fwd_e fwd_sel(sb_entry_t e);
    if (e.valid && e.age == 2'd0 && !e.is_load)
      return FWD_EX_MEM;
    if (e.valid && e.age == 2'd1)
      return FWD_MEM_WB;
    return FWD_REGFILE;
  endfunction

endpackage

// File: rtl/reg_scoreboard_if.sv
// Issue/writeback/operand bundle between the pipeline
// control and the register scoreboard.
interface reg_scoreboard_if;

  logic       pipe_advance;
  logic       issue_valid;
  logic [4:0] issue_rd;
  logic       issue_is_load;
  logic       wb_valid;
  logic [4:0] wb_rd;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;
  logic       PC_Enable;
  logic       IF_ID_Pipeline_Enable;
  logic       id_ex_flush;
  logic [5:0] pending_count;
  logic [15:0] stall_cycles;

  modport master (
    output pipe_advance, issue_valid, issue_rd,
    output issue_is_load, wb_valid, wb_rd,
    output id_rs, id_rt,
    input  fwd_a, fwd_b, PC_Enable,
    input  IF_ID_Pipeline_Enable, id_ex_flush,
    input  pending_count, stall_cycles
  );

  modport slave (
    input  pipe_advance, issue_valid, issue_rd,
    input  issue_is_load, wb_valid, wb_rd,
    input  id_rs, id_rt,
    output fwd_a, fwd_b, PC_Enable,
    output IF_ID_Pipeline_Enable, id_ex_flush,
    output pending_count, stall_cycles
  );

endinterface

// File: rtl/reg_scoreboard_sb_entry.sv
// One tracked architectural register: valid, load flag
// and pipeline age of its most recent in-flight writer.
module sb_entry
  import mips_pkg::*;
#(
  parameter int MAX_AGE = MAX_AGE_DEF
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      adv_i,
  input  logic      set_i,
  input  logic      is_load_i,
  input  logic      clr_i,
  output sb_entry_t state_o
);

  localparam logic [1:0] AGE_MAX = 2'(MAX_AGE);

  sb_entry_t state_q;
  sb_entry_t state_d;

  // A new issue beats a same-edge writeback of the older writer.
  always_comb begin
    state_d = state_q;
    if (set_i) begin
      state_d.valid   = 1'b1;
      state_d.is_load = is_load_i;
      state_d.age     = 2'd0;
    end else if (clr_i) begin
      state_d = '0;
    end else if (adv_i && state_q.valid) begin
      if (state_q.age < AGE_MAX)
        state_d.age = state_q.age + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= '0;
    else       state_q <= state_d;
  end

  assign state_o = state_q;

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard: load-use stall detection, operand
// forwarding select and in-flight writer bookkeeping.
module reg_scoreboard
  import mips_pkg::*;
#(
  parameter int NREGS   = NREGS_DEF,
  parameter int MAX_AGE = MAX_AGE_DEF
) (
  input  logic       clk,
  input  logic       reset,
  reg_scoreboard_if.slave sb
);

  sb_entry_t ent [1:NREGS-1];
  sb_entry_t ea;
  sb_entry_t eb;
  logic      load_use_a;
  logic      load_use_b;
  logic      stall;
  logic      issue_go;
  logic [5:0]  pend;
  logic [15:0] stall_cycles_q;
  logic [15:0] stall_cycles_d;

  assign issue_go = sb.pipe_advance & sb.issue_valid
                  & (sb.issue_rd != 5'd0) & ~stall;

  for (genvar r = 1; r < NREGS; r++) begin : g_ent
    sb_entry #(.MAX_AGE(MAX_AGE)) u_ent (
      .clk       (clk),
      .reset     (reset),
      .adv_i     (sb.pipe_advance),
      .set_i     (issue_go && sb.issue_rd == 5'(r)),
      .is_load_i (sb.issue_is_load),
      .clr_i     (sb.wb_valid && sb.wb_rd == 5'(r)),
      .state_o   (ent[r])
    );
  end

  // Operand 0 matches no entry and so reads as empty.
  always_comb begin
    ea = '0;
    eb = '0;
    for (int r = 1; r < NREGS; r++) begin
      if (sb.id_rs == 5'(r)) ea = ent[r];
      if (sb.id_rt == 5'(r)) eb = ent[r];
    end
  end

  assign load_use_a = ea.valid & ea.is_load
                    & (ea.age == 2'd0);
  assign load_use_b = eb.valid & eb.is_load
                    & (eb.age == 2'd0);
  assign stall      = load_use_a | load_use_b;

  always_comb begin
    pend = '0;
    for (int r = 1; r < NREGS; r++)
      pend = pend + 6'(ent[r].valid);
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall && stall_cycles_q != 16'hFFFF)
      stall_cycles_d = stall_cycles_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_cycles_q <= '0;
    else       stall_cycles_q <= stall_cycles_d;
  end

  assign sb.fwd_a                 = fwd_sel(ea);
  assign sb.fwd_b                 = fwd_sel(eb);
  assign sb.PC_Enable             = ~stall;
  assign sb.IF_ID_Pipeline_Enable = ~stall;
  assign sb.id_ex_flush           = stall;
  assign sb.pending_count         = pend;
  assign sb.stall_cycles          = stall_cycles_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed scoreboard bench for reg_scoreboard: expected
// output sets are queued per step and popped at sampling.
module tb_reg_scoreboard;

  typedef struct {
    string       tag;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic        pce;
    logic        flush;
    logic [5:0]  pend;
    logic [15:0] stalls;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   compared = 0;
  int   mismatched = 0;
  exp_t q [$];

  always #5 clk = ~clk;

  reg_scoreboard_if sb_if ();

  reg_scoreboard #(.NREGS(32), .MAX_AGE(2)) dut (
    .clk   (clk),
    .reset (reset),
    .sb    (sb_if)
  );

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic push(string tag, logic [1:0] fa,
                      logic [1:0] fb, logic pce,
                      logic [5:0] pend, logic [15:0] st);
    exp_t e;
    e.tag = tag; e.fa = fa; e.fb = fb;
    e.pce = pce; e.flush = ~pce;
    e.pend = pend; e.stalls = st;
    q.push_back(e);
  endtask

  task automatic compare_top();
    exp_t e;
    if (q.size() == 0) begin
      compared++;
      mismatched++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = q.pop_front();
      chk({e.tag, ".fwd_a"}, 32'(sb_if.fwd_a), 32'(e.fa));
      chk({e.tag, ".fwd_b"}, 32'(sb_if.fwd_b), 32'(e.fb));
      chk({e.tag, ".pc_en"}, 32'(sb_if.PC_Enable),
          32'(e.pce));
      chk({e.tag, ".ifid_en"},
          32'(sb_if.IF_ID_Pipeline_Enable), 32'(e.pce));
      chk({e.tag, ".flush"}, 32'(sb_if.id_ex_flush),
          32'(e.flush));
      chk({e.tag, ".pend"}, 32'(sb_if.pending_count),
          32'(e.pend));
      chk({e.tag, ".stalls"}, 32'(sb_if.stall_cycles),
          32'(e.stalls));
    end
  endtask

  task automatic drive(logic adv, logic iv, int ird,
                       logic ild, logic wv, int wrd,
                       int rs, int rt);
    sb_if.pipe_advance  = adv;
    sb_if.issue_valid   = iv;
    sb_if.issue_rd      = 5'(ird);
    sb_if.issue_is_load = ild;
    sb_if.wb_valid      = wv;
    sb_if.wb_rd         = 5'(wrd);
    sb_if.id_rs         = 5'(rs);
    sb_if.id_rt         = 5'(rt);
  endtask

  // Sample mid-cycle, then let the rising edge commit.
  task automatic settle();
    @(negedge clk);
    compare_top();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    push("reset", 2'b00, 2'b00, 1, 0, 0);
    @(negedge clk);
    compare_top();
    @(posedge clk);
    #1 reset = 1'b0;

    // non-load producer forwards from EX/MEM, then MEM/WB
    drive(1, 1, 5, 0, 0, 0, 0, 0);
    push("iss5", 2'b00, 2'b00, 1, 0, 0); settle();
    drive(1, 0, 0, 0, 0, 0, 5, 0);
    push("fwd5_exmem", 2'b10, 2'b00, 1, 1, 0); settle();
    drive(0, 0, 0, 0, 0, 0, 5, 0);
    push("fwd5_memwb", 2'b01, 2'b00, 1, 1, 0); settle();
    drive(1, 0, 0, 0, 0, 0, 5, 0);
    push("hold5_memwb", 2'b01, 2'b00, 1, 1, 0); settle();
    drive(1, 0, 0, 0, 1, 5, 5, 0);
    push("age5_sat", 2'b00, 2'b00, 1, 1, 0); settle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    push("wb5_done", 2'b00, 2'b00, 1, 0, 0); settle();

    // load-use on rt: one stall, blocked issue of $9
    drive(1, 1, 8, 1, 0, 0, 0, 0);
    push("iss_ld8", 2'b00, 2'b00, 1, 0, 0); settle();
    drive(1, 1, 9, 0, 0, 0, 0, 8);
    push("ld8_stall", 2'b00, 2'b00, 0, 1, 0); settle();
    drive(1, 0, 0, 0, 0, 0, 0, 8);
    push("ld8_memwb", 2'b00, 2'b01, 1, 1, 1); settle();
    drive(0, 0, 0, 0, 1, 8, 0, 8);
    push("ld8_wb", 2'b00, 2'b00, 1, 1, 1); settle();

    // $3 through the pipe, then written back
    drive(1, 1, 3, 0, 0, 0, 0, 0);
    push("iss3", 2'b00, 2'b00, 1, 0, 1); settle();
    drive(1, 0, 0, 0, 0, 0, 3, 0);
    push("fwd3_exmem", 2'b10, 2'b00, 1, 1, 1); settle();
    drive(1, 0, 0, 0, 0, 0, 3, 0);
    push("fwd3_memwb", 2'b01, 2'b00, 1, 1, 1); settle();
    drive(0, 0, 0, 0, 1, 3, 3, 0);
    push("wb3_pend1", 2'b00, 2'b00, 1, 1, 1); settle();
    drive(0, 0, 0, 0, 0, 0, 3, 0);
    push("wb3_pend0", 2'b00, 2'b00, 1, 0, 1); settle();

    // same-edge issue and writeback of $7
    drive(1, 1, 7, 0, 1, 7, 0, 0);
    push("iss_wb7", 2'b00, 2'b00, 1, 0, 1); settle();
    drive(0, 0, 0, 0, 0, 0, 7, 0);
    push("iss7_wins", 2'b10, 2'b00, 1, 1, 1); settle();

    // issue to $0 creates nothing
    drive(1, 1, 0, 1, 0, 0, 0, 0);
    push("iss_r0", 2'b00, 2'b00, 1, 1, 1); settle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    push("r0_none", 2'b00, 2'b00, 1, 1, 1); settle();

    // three outstanding, stalling, then reset mid-cycle
    drive(1, 1, 10, 1, 0, 0, 7, 0);
    push("iss_ld10", 2'b01, 2'b00, 1, 1, 1); settle();
    drive(1, 1, 11, 1, 0, 0, 0, 0);
    push("iss_ld11", 2'b00, 2'b00, 1, 2, 1); settle();
    drive(0, 0, 0, 0, 0, 0, 11, 10);
    push("three_out", 2'b00, 2'b01, 0, 3, 1); settle();
    #2 reset = 1'b1;
    #1;
    push("mid_reset", 2'b00, 2'b00, 1, 0, 0);
    compare_top();
    @(posedge clk);
    #1 reset = 1'b0;

    drive(1, 1, 12, 0, 0, 0, 0, 0);
    push("post_rst_iss", 2'b00, 2'b00, 1, 0, 0); settle();
    drive(0, 0, 0, 0, 0, 0, 12, 0);
    push("post_rst_fwd", 2'b10, 2'b00, 1, 1, 0); settle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 SHALL have parameter NREGS, default 32, meaning number of architectural registers tracked (register 0 is never tracked).
REQ-002 SHALL have parameter MAX_AGE, default 2, meaning age at which an entry is treated as written back (EX=0, MEM=1, WB=2).
REQ-003 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port pipe_advance  in  1  pipeline moves one stage this cycle.
REQ-006 SHALL have port issue_valid  in  1  decoded instruction enters EX this cycle.
REQ-007 SHALL have port issue_rd  in  5  destination register of the issuing instruction.
REQ-008 SHALL have port issue_is_load  in  1  the issuing instruction is a load.
REQ-009 SHALL have port wb_valid  in  1  register-file write occurs this cycle.
REQ-010 SHALL have port wb_rd  in  5  register being written back.
REQ-011 SHALL have ports id_rs and id_rt  in  5 each  source operands of the instruction currently in ID.
REQ-012 SHALL have ports fwd_a and fwd_b  out  2 each  operand source once the ID instruction reaches EX: 00 register file, 10 EX/MEM, 01 MEM/WB.
REQ-013 SHALL have ports PC_Enable and IF_ID_Pipeline_Enable  out  1 each  low while stalling.
REQ-014 SHALL have port id_ex_flush  out  1  insert a bubble into ID/EX.
REQ-015 SHALL have port pending_count  out  6  number of valid entries.
REQ-016 SHALL have port stall_cycles  out  16  saturating count of stall cycles.

Function
REQ-017 SHALL keep per register r (1..NREGS-1) the state valid, is_load and a 2-bit age.
REQ-018 SHALL, on a rising edge with pipe_advance=1, issue_valid=1, issue_rd!=0 and no stall, set entry issue_rd to valid=1, is_load=issue_is_load, age=0.
REQ-019 SHALL, on each rising edge with pipe_advance=1, increment the age of every other valid entry, saturating at MAX_AGE.
REQ-020 SHALL, on a rising edge with wb_valid=1 and wb_rd!=0, clear entry wb_rd; wb_valid is honoured regardless of pipe_advance.
REQ-021 SHALL, when issue and writeback target the same register on the same edge, give the issue priority (entry left valid, age 0).
REQ-022 SHALL, when pipe_advance=0, ignore issue_valid and hold all ages.
REQ-023 SHALL, per operand x, raise load_use_x when x!=0, entry x is valid, is_load=1 and age=0.
REQ-024 SHALL compute forwarding combinationally per operand with this priority:
- entry x valid and age 0, not a load: 10
- entry x valid and age 1: 01
- otherwise (including operand 0): 00
REQ-025 SHALL assert stall = load_use_a OR load_use_b.
REQ-026 SHALL drive, while stall=1: PC_Enable=0, IF_ID_Pipeline_Enable=0, id_ex_flush=1, and no new entry is created.
REQ-027 SHALL update pending_count in the same cycle as the entry changes it reflects.
REQ-028 SHALL increment stall_cycles on each edge where stall=1, saturating at 16'hFFFF.
REQ-029 SHALL produce its outputs combinationally from registered state and the current inputs, with zero-cycle latency.

Reset
REQ-030 SHALL, while reset=1, asynchronously clear all valid, is_load and age bits, set pending_count=0 and stall_cycles=0, and drive PC_Enable=1, IF_ID_Pipeline_Enable=1, id_ex_flush=0, fwd_a=fwd_b=00.
REQ-031 SHALL, when reset is asserted in mid-operation, discard all in-flight entries; the first edge after deassertion operates normally.

Structure
REQ-032 SHALL take FWD_REGFILE/FWD_EX_MEM/FWD_MEM_WB codes and the NREGS/MAX_AGE defaults from the shared package mips_pkg.
REQ-033 SHALL implement per-register state in sub-module sb_entry, with NREGS-1 instances.

Verification
REQ-034 SHALL cover: issue $5 (non-load), then id_rs=5 next cycle -> fwd_a=10, no stall.
REQ-035 SHALL cover: issue load $8, then id_rt=8 next cycle -> stall=1 for one cycle, PC_Enable=0, id_ex_flush=1; after advance, fwd_b=01.
REQ-036 SHALL cover: issue $3, two advances, then wb $3 -> pending_count 1->0, fwd_a=00 for id_rs=3.
REQ-037 SHALL cover: issue $7 and wb $7 on the same edge -> entry valid with age 0, pending_count=1.
REQ-038 SHALL cover: issue $0 (load), id_rs=0 -> no entry created, no stall, fwd_a=00.
REQ-039 SHALL cover: three outstanding entries, then assert reset mid-cycle -> outputs at reset values immediately, pending_count=0, stall_cycles=0.
